// File: rtl/if_fetch_unit_if.sv
// Bundle for the instruction-memory request/response port and the fetch-to-decode port
// of if_fetch_unit. The master modport is the fetch unit side.
interface if_fetch_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             imem_req;
  logic [WIDTH-1:0] imem_addr;
  logic             imem_ready;
  logic             imem_rvalid;
  logic [WIDTH-1:0] imem_rdata;
  logic             if_valid;
  logic [WIDTH-1:0] if_instr;
  logic [WIDTH-1:0] if_pc;
  logic             id_stall;

  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ready, imem_rvalid, imem_rdata, id_stall
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ready, imem_rvalid, imem_rdata, id_stall
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: one outstanding imem request, {pc, instr} buffer to decode.
// Optional stall-cycle counter output enabled by defining IF_FETCH_PERF_EN.
module if_fetch_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      pc,
  input  logic                  flush,
  output logic                  stall_pc,
  if_fetch_unit_if.master       bus
`ifdef IF_FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_stall_cnt
`endif
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StWait, StDrop} state_e;

  state_e           state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [WIDTH-1:0] req_pc_q, req_pc_d;
  logic [WIDTH-1:0] buf_pc_q    [DEPTH];
  logic [WIDTH-1:0] buf_pc_d    [DEPTH];
  logic [WIDTH-1:0] buf_instr_q [DEPTH];
  logic [WIDTH-1:0] buf_instr_d [DEPTH];

  logic full, req, accept, valid, push, pop;

  // Full is judged on the count before any same-cycle pop.
  assign full   = (count_q == CntW'(DEPTH));
  assign req    = rst & (state_q == StIdle) & ~flush & ~full;
  assign accept = req & bus.imem_ready;
  assign valid  = rst & (count_q != '0);
  assign pop    = valid & ~bus.id_stall & ~flush;
  assign push   = rst & (state_q == StWait) & bus.imem_rvalid & ~flush;

  assign bus.imem_req  = req;
  assign bus.imem_addr = rst ? pc : '0;
  assign bus.if_valid  = valid;
  assign bus.if_pc     = buf_pc_q[rd_ptr_q];
  assign bus.if_instr  = buf_instr_q[rd_ptr_q];
  assign stall_pc      = rst ? (~accept & ~flush) : 1'b1;

  always_comb begin
    state_d  = state_q;
    req_pc_d = accept ? pc : req_pc_q;
    unique case (state_q)
      StIdle: if (accept) state_d = StWait;
      // A response landing in the flush cycle itself closes the request outright.
      StWait: begin
        if (bus.imem_rvalid) state_d = StIdle;
        else if (flush)      state_d = StDrop;
      end
      StDrop: if (bus.imem_rvalid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    buf_pc_d    = buf_pc_q;
    buf_instr_d = buf_instr_q;
    if (flush) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (push) begin
        buf_pc_d[wr_ptr_q]    = req_pc_q;
        buf_instr_d[wr_ptr_q] = bus.imem_rdata;
        wr_ptr_d              = wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      req_pc_q <= req_pc_d;
    end
  end

  // Buffer storage needs no reset: entries are only read while count is non-zero.
  always_ff @(posedge clk) begin
    buf_pc_q    <= buf_pc_d;
    buf_instr_q <= buf_instr_d;
  end

`ifdef IF_FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_pc && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst) stall_cnt_q <= '0;
    else      stall_cnt_q <= stall_cnt_d;
  end

  assign fetch_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed cycle table, then randomized traffic against a
// queue-based model of the fetch buffer and the single outstanding request.
module tb_if_fetch_unit;
  localparam int unsigned DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc;
  logic        flush;
  logic        stall_pc;
`ifdef IF_FETCH_PERF_EN
  logic [31:0] fetch_stall_cnt;
`endif

  if_fetch_unit_if #(.WIDTH(32)) bus ();

  if_fetch_unit #(.WIDTH(32), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .pc       (pc),
    .flush    (flush),
    .stall_pc (stall_pc),
    .bus      (bus)
`ifdef IF_FETCH_PERF_EN
    ,
    .fetch_stall_cnt (fetch_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] pc;
    bit          fl, rdy, rv;
    logic [31:0] rd;
    bit          ids;
    bit          e_req, e_stall, e_valid;
    logic [31:0] e_hpc, e_hinstr;
  } vec_t;

  vec_t tbl[$];

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  task automatic add(input logic [31:0] p, input bit fl, rdy, rv, input logic [31:0] rd,
                     input bit ids, er, es, ev, input logic [31:0] hp, hi);
    vec_t v;
    v.pc = p; v.fl = fl; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ids = ids;
    v.e_req = er; v.e_stall = es; v.e_valid = ev; v.e_hpc = hp; v.e_hinstr = hi;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input bit er, input logic [31:0] ea, input bit es,
                           input bit ev, input logic [31:0] hp, input logic [31:0] hi);
    chk({tag, " imem_req"}, 32'(bus.imem_req), 32'(er));
    chk({tag, " imem_addr"}, bus.imem_addr, ea);
    chk({tag, " stall_pc"}, 32'(stall_pc), 32'(es));
    chk({tag, " if_valid"}, 32'(bus.if_valid), 32'(ev));
    if (ev) begin
      chk({tag, " if_pc"}, bus.if_pc, hp);
      chk({tag, " if_instr"}, bus.if_instr, hi);
    end
  endtask

  task automatic drive(input bit r, input logic [31:0] p, input bit fl, rdy, rv,
                       input logic [31:0] rd, input bit ids);
    rst = r; pc = p; flush = fl;
    bus.imem_ready = rdy; bus.imem_rvalid = rv; bus.imem_rdata = rd; bus.id_stall = ids;
  endtask

  task automatic do_reset(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      drive(1'b0, 32'h123, 1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
      #3;
      check_out($sformatf("reset%0d", i), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
    end
  endtask

  // Reference model state
  ent_t        mq[$];
  bit          m_busy, m_dead;
  logic [31:0] m_busy_pc;
  bit          mem_busy;
  int          mem_left;
  longint      exp_cnt;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] cnt_a, cnt_b;
    logic [31:0] cur_pc;
    bit          rv, fl, rdy, ids, do_rst, e_req, e_stall, e_valid;
    logic [31:0] rd;
    cnt_a = '0; cnt_b = '0;

    // Basic fetch, buffer full, flush with request outstanding
    add(32'h00, 0, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0,  32'h0);
    add(32'h04, 0, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h04, 0, 1, 1, 32'h20080005, 0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h04, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'h0,  32'h20080005);
    add(32'h08, 0, 1, 0, 32'h0,        1, 0, 1, 1, 32'h0,  32'h20080005);
    add(32'h08, 0, 1, 1, 32'h11111111, 1, 0, 1, 1, 32'h0,  32'h20080005);
    add(32'h08, 0, 1, 0, 32'h0,        1, 0, 1, 1, 32'h0,  32'h20080005);
    add(32'h08, 0, 1, 0, 32'h0,        1, 0, 1, 1, 32'h0,  32'h20080005);
    add(32'h08, 0, 1, 0, 32'h0,        0, 0, 1, 1, 32'h0,  32'h20080005);
    add(32'h08, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'h4,  32'h11111111);
    add(32'h0C, 1, 1, 0, 32'h0,        1, 0, 0, 1, 32'h4,  32'h11111111);
    add(32'h40, 0, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h40, 0, 1, 1, 32'hDEADBEEF, 0, 0, 1, 0, 32'h0,  32'h0);
    // Memory backpressure: rows 13..17
    for (int i = 0; i < 5; i++) add(32'h40, 0, 0, 0, 32'h0, 0, 1, 1, 0, 32'h0, 32'h0);
    add(32'h40, 0, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0,  32'h0);
    add(32'h44, 0, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h44, 0, 1, 1, 32'hAAAA0001, 0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h44, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'h40, 32'hAAAA0001);
    add(32'h48, 0, 1, 0, 32'h0,        1, 0, 1, 1, 32'h40, 32'hAAAA0001);
    add(32'h48, 0, 1, 1, 32'hBBBB0002, 1, 0, 1, 1, 32'h40, 32'hAAAA0001);
    add(32'h48, 0, 1, 0, 32'h0,        1, 0, 1, 1, 32'h40, 32'hAAAA0001);
    // Flush with full buffer and same-cycle pop
    add(32'h48, 1, 1, 0, 32'h0,        0, 0, 0, 1, 32'h40, 32'hAAAA0001);
    add(32'h80, 0, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0,  32'h0);
    add(32'h84, 0, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h84, 0, 1, 1, 32'hCCCC0003, 0, 0, 1, 0, 32'h0,  32'h0);
    add(32'h84, 0, 1, 0, 32'h0,        1, 1, 0, 1, 32'h80, 32'hCCCC0003);
    // Flush with pop and rvalid in the same cycle: data dropped, back to idle
    add(32'h88, 1, 1, 1, 32'hDDDD0004, 0, 0, 0, 1, 32'h80, 32'hCCCC0003);
    add(32'hC0, 0, 1, 0, 32'h0,        0, 1, 0, 0, 32'h0,  32'h0);
    add(32'hC4, 0, 1, 0, 32'h0,        0, 0, 1, 0, 32'h0,  32'h0);
    add(32'hC4, 0, 1, 1, 32'hEEEE0005, 0, 0, 1, 0, 32'h0,  32'h0);
    add(32'hC4, 0, 0, 0, 32'h0,        0, 1, 1, 1, 32'hC0, 32'hEEEE0005);
    add(32'hC4, 0, 0, 0, 32'h0,        0, 1, 1, 0, 32'h0,  32'h0);

    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    do_reset(2);

    exp_cnt = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      @(posedge clk); #1;
      drive(1'b1, tbl[i].pc, tbl[i].fl, tbl[i].rdy, tbl[i].rv, tbl[i].rd, tbl[i].ids);
      #3;
      check_out($sformatf("row%0d", i), tbl[i].e_req, tbl[i].pc, tbl[i].e_stall,
                tbl[i].e_valid, tbl[i].e_hpc, tbl[i].e_hinstr);
`ifdef IF_FETCH_PERF_EN
      chk($sformatf("row%0d stall_cnt", i), fetch_stall_cnt, 32'(exp_cnt));
      if (i == 13) cnt_a = fetch_stall_cnt;
      if (i == 18) begin
        cnt_b = fetch_stall_cnt;
        chk("backpressure stall_cnt delta", cnt_b - cnt_a, 32'd5);
      end
`endif
      if (tbl[i].e_stall) exp_cnt++;
    end

    // Randomized traffic
    do_reset(1);
    mq.delete(); m_busy = 0; m_dead = 0; m_busy_pc = '0; mem_busy = 0; mem_left = 0;
    exp_cnt = 0; cur_pc = 32'h1000;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      do_rst = ($urandom_range(0, 299) == 0);
      rv = 1'b0;
      if (mem_busy) begin
        mem_left--;
        if (mem_left == 0) begin rv = 1'b1; mem_busy = 0; end
      end
      fl  = ($urandom_range(0, 11) == 0);
      rdy = ($urandom_range(0, 3) != 0);
      ids = ($urandom_range(0, 2) == 0);
      rd  = $urandom;
      drive(!do_rst, cur_pc, fl, rdy, rv, rd, ids);
      #3;
      if (do_rst) begin
        check_out($sformatf("rnd%0d rst", c), 1'b0, 32'h0, 1'b1, 1'b0, 32'h0, 32'h0);
        mq.delete(); m_busy = 0; m_dead = 0; mem_busy = 0; exp_cnt = 0;
        continue;
      end
      e_req   = !m_busy && !fl && (mq.size() < DEPTH);
      e_stall = !(e_req && rdy) && !fl;
      e_valid = (mq.size() != 0);
      check_out($sformatf("rnd%0d", c), e_req, cur_pc, e_stall, e_valid,
                e_valid ? mq[0].pc : 32'h0, e_valid ? mq[0].instr : 32'h0);
`ifdef IF_FETCH_PERF_EN
      chk($sformatf("rnd%0d stall_cnt", c), fetch_stall_cnt, 32'(exp_cnt));
`endif
      if (e_stall && exp_cnt != 64'hFFFFFFFF) exp_cnt++;
      if (fl) begin
        mq.delete();
        if (m_busy) begin
          if (rv) begin m_busy = 0; m_dead = 0; end
          else m_dead = 1;
        end
      end else begin
        if (e_valid && !ids) void'(mq.pop_front());
        if (m_busy && rv) begin
          if (!m_dead) mq.push_back({m_busy_pc, rd});
          m_busy = 0; m_dead = 0;
        end
      end
      if (e_req && rdy) begin
        m_busy = 1; m_dead = 0; m_busy_pc = cur_pc;
        mem_busy = 1; mem_left = $urandom_range(1, 3);
      end
      if (fl) cur_pc = $urandom & 32'h0000FFFC;
      else if (!e_stall) cur_pc = cur_pc + 32'd4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
